// File: rtl/mips_pc_pkg.sv
// mips_pc_pkg: shared state/redirect-source types, default vectors and target alignment
package mips_pc_pkg;
  typedef enum logic [1:0] {RUN, PEND, HALTED} state_e;
  typedef enum logic [2:0] {SRC_SEQ, SRC_EXC, SRC_ERET, SRC_BRANCH, SRC_JUMP} src_e;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;
  function automatic logic [31:0] align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/redirect inputs and fetch-address outputs of the PC sequencer
// step_mode/step exist only when PC_STEP_EN is defined
interface pc_sequencer_if;
  logic stall, branch_taken, jump, exc_req, eret, halt;
  logic [31:0] branch_target, jump_target, exc_pc;
  logic [31:0] pc, epc;
  logic pc_valid, flush, halted;
`ifdef PC_STEP_EN
  logic step_mode, step;
`endif
  modport master(
    output stall, branch_taken, branch_target, jump, jump_target, exc_req, exc_pc, eret, halt,
`ifdef PC_STEP_EN
    output step_mode, step,
`endif
    input pc, pc_valid, flush, epc, halted
  );
  modport slave(
    input stall, branch_taken, branch_target, jump, jump_target, exc_req, exc_pc, eret, halt,
`ifdef PC_STEP_EN
    input step_mode, step,
`endif
    output pc, pc_valid, flush, epc, halted
  );
endinterface

// File: rtl/pc_target_sel.sv
// pc_target_sel: priority pick of the next fetch target (exc > eret > branch > jump > pc+4), word-aligned
import mips_pc_pkg::*;
module pc_target_sel #(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [31:0] pc,
  input  logic [31:0] epc,
  input  logic        exc_req,
  input  logic        eret,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] target,
  output src_e        src
);
  always_comb begin
    src = exc_req ? SRC_EXC : eret ? SRC_ERET : branch_taken ? SRC_BRANCH : jump ? SRC_JUMP : SRC_SEQ;
    target = exc_req ? align(EXC_VECTOR) : eret ? align(epc) : branch_taken ? align(branch_target) :
             jump ? align(jump_target) : pc + 32'd4;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: MIPS PC owner with stall hold, deferred redirects, exceptions and halt
// optional single-step gating of sequential/pending advance under PC_STEP_EN
import mips_pc_pkg::*;
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input logic clk,
  input logic reset,
  pc_sequencer_if.slave bus
);
  state_e state, state_n;
  src_e src;
  logic [31:0] pc, pc_n, epc, epc_n, pend, pend_n, target;
  logic pc_valid, flush, flush_n, hold;
  pc_target_sel #(.EXC_VECTOR(EXC_VECTOR)) u_sel (
    .pc(pc),
    .epc(epc),
    .exc_req(bus.exc_req),
    .eret(bus.eret),
    .branch_taken(bus.branch_taken),
    .branch_target(bus.branch_target),
    .jump(bus.jump),
    .jump_target(bus.jump_target),
    .target(target),
    .src(src)
  );
`ifdef PC_STEP_EN
  assign hold = bus.stall | (bus.step_mode & ~bus.step);
`else
  assign hold = bus.stall;
`endif
  // pc_valid low means the first post-reset cycle, which fetches RESET_VECTOR before advancing
  always_comb begin
    state_n = state;
    pc_n = pc;
    epc_n = epc;
    pend_n = pend;
    flush_n = 1'b0;
    if (state != HALTED) begin
      if (src == SRC_EXC || src == SRC_ERET) begin
        pc_n = target;
        epc_n = src == SRC_EXC ? bus.exc_pc : epc;
        pend_n = '0;
        flush_n = 1'b1;
        state_n = RUN;
      end else if (bus.halt) begin
        state_n = HALTED;
      end else if (src != SRC_SEQ) begin
        pend_n = bus.stall ? target : pend;
        pc_n = bus.stall ? pc : target;
        flush_n = ~bus.stall;
        state_n = bus.stall ? PEND : RUN;
      end else if (state == PEND) begin
        pc_n = hold ? pc : pend;
        flush_n = ~hold;
        state_n = hold ? PEND : RUN;
      end else begin
        pc_n = (hold || !pc_valid) ? pc : target;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
      pc <= RESET_VECTOR;
      epc <= '0;
      pend <= '0;
      pc_valid <= 1'b0;
      flush <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      epc <= epc_n;
      pend <= pend_n;
      pc_valid <= state_n != HALTED;
      flush <= flush_n;
    end
  end
  assign bus.pc = pc;
  assign bus.epc = epc;
  assign bus.pc_valid = pc_valid;
  assign bus.flush = flush;
  assign bus.halted = state == HALTED;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: vector table + scoreboard bench for pc_sequencer
module tb_pc_sequencer;
  typedef struct {
    logic rst, stall, br, j, exc, eret, halt;
    logic [31:0] bt, jt, xpc;
    logic [31:0] pc, epc;
    logic f, h, v;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  vec_t q[$];
  vec_t vt[$];
  pc_sequencer_if bus();
  pc_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t mk(logic rst, logic stall, logic br, logic [31:0] bt, logic j, logic [31:0] jt,
                              logic exc, logic [31:0] xpc, logic eret, logic halt,
                              logic [31:0] pc, logic f, logic [31:0] epc, logic h, logic v);
    vec_t r;
    r.rst = rst; r.stall = stall; r.br = br; r.bt = bt; r.j = j; r.jt = jt;
    r.exc = exc; r.xpc = xpc; r.eret = eret; r.halt = halt;
    r.pc = pc; r.f = f; r.epc = epc; r.h = h; r.v = v;
    return r;
  endfunction
  task automatic apply(input vec_t v);
    @(negedge clk);
    reset = v.rst;
    bus.stall = v.stall; bus.branch_taken = v.br; bus.branch_target = v.bt;
    bus.jump = v.j; bus.jump_target = v.jt; bus.exc_req = v.exc; bus.exc_pc = v.xpc;
    bus.eret = v.eret; bus.halt = v.halt;
    q.push_back(v);
  endtask
  task automatic chk(input string n, input int idx, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s vec %0d got %h want %h", n, idx, a, x);
    end
  endtask
  int seen = 0;
  always @(posedge clk) begin : mon
    vec_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("pc", seen, bus.pc, e.pc);
      chk("flush", seen, {31'd0, bus.flush}, {31'd0, e.f});
      chk("epc", seen, bus.epc, e.epc);
      chk("halted", seen, {31'd0, bus.halted}, {31'd0, e.h});
      chk("pc_valid", seen, {31'd0, bus.pc_valid}, {31'd0, e.v});
      seen++;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b0;
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0; bus.jump = 0; bus.jump_target = 0;
    bus.exc_req = 0; bus.exc_pc = 0; bus.eret = 0; bus.halt = 0;
`ifdef PC_STEP_EN
    bus.step_mode = 0; bus.step = 0;
`endif
    //            rst st br bt            j  jt            ex xpc    er ht  pc            f  epc      h  v
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,     0, 0, 32'h0,        0, 32'h0,  0, 0));
    vt.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,     0, 0, 32'h0,        0, 32'h0,  0, 1));
    vt.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,     0, 0, 32'h4,        0, 32'h0,  0, 1));
    vt.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,     0, 0, 32'h8,        0, 32'h0,  0, 1));
    vt.push_back(mk(1, 0, 1, 32'h103,      0, 0,            0, 0,     0, 0, 32'h100,      1, 32'h0,  0, 1));
    vt.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,     0, 0, 32'h104,      0, 32'h0,  0, 1));
    vt.push_back(mk(1, 1, 0, 0,            1, 32'h200,      0, 0,     0, 0, 32'h104,      0, 32'h0,  0, 1));
    vt.push_back(mk(1, 1, 0, 0,            1, 32'h200,      0, 0,     0, 0, 32'h104,      0, 32'h0,  0, 1));
    vt.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,     0, 0, 32'h200,      1, 32'h0,  0, 1));
    vt.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,     0, 0, 32'h204,      0, 32'h0,  0, 1));
    vt.push_back(mk(1, 0, 1, 32'h300,      0, 0,            1, 32'h44,0, 0, 32'h80,       1, 32'h44, 0, 1));
    vt.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,     0, 0, 32'h84,       0, 32'h44, 0, 1));
    vt.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,     1, 0, 32'h44,       1, 32'h44, 0, 1));
    vt.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,     0, 0, 32'h48,       0, 32'h44, 0, 1));
    vt.push_back(mk(1, 1, 1, 32'h400,      0, 0,            0, 0,     0, 0, 32'h48,       0, 32'h44, 0, 1));
    vt.push_back(mk(1, 1, 0, 0,            1, 32'h503,      0, 0,     0, 0, 32'h48,       0, 32'h44, 0, 1));
    vt.push_back(mk(1, 1, 0, 0,            0, 0,            0, 0,     0, 0, 32'h48,       0, 32'h44, 0, 1));
    vt.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,     0, 0, 32'h500,      1, 32'h44, 0, 1));
    vt.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,     0, 0, 32'h504,      0, 32'h44, 0, 1));
    vt.push_back(mk(1, 1, 0, 0,            0, 0,            0, 0,     0, 0, 32'h504,      0, 32'h44, 0, 1));
    vt.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,     0, 0, 32'h508,      0, 32'h44, 0, 1));
    vt.push_back(mk(1, 0, 0, 0,            1, 32'hFFFF_FFFF,0, 0,     0, 0, 32'hFFFF_FFFC,1, 32'h44, 0, 1));
    vt.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,     0, 0, 32'h0,        0, 32'h44, 0, 1));
    vt.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,     0, 0, 32'h4,        0, 32'h44, 0, 1));
    foreach (vt[i]) apply(vt[i]);
    // exception during a pending redirect discards it; eret aligns the saved pc
    apply(mk(1, 1, 1, 32'h600, 0, 0, 0, 0,      0, 0, 32'h4,  0, 32'h44, 0, 1));
    apply(mk(1, 1, 0, 0,       0, 0, 1, 32'h13, 0, 0, 32'h80, 1, 32'h13, 0, 1));
    apply(mk(1, 0, 0, 0,       0, 0, 0, 0,      0, 0, 32'h84, 0, 32'h13, 0, 1));
    apply(mk(1, 0, 0, 0,       0, 0, 0, 0,      1, 0, 32'h10, 1, 32'h13, 0, 1));
    apply(mk(1, 0, 0, 0,       0, 0, 0, 0,      0, 0, 32'h14, 0, 32'h13, 0, 1));
    // reset mid-PEND drops the pending target
    apply(mk(1, 1, 0, 0,       1, 32'h700, 0, 0, 0, 0, 32'h14, 0, 32'h13, 0, 1));
    apply(mk(0, 0, 0, 0,       0, 0, 0, 0,      0, 0, 32'h0,  0, 32'h0,  0, 0));
    apply(mk(1, 0, 0, 0,       0, 0, 0, 0,      0, 0, 32'h0,  0, 32'h0,  0, 1));
    apply(mk(1, 0, 0, 0,       0, 0, 0, 0,      0, 0, 32'h4,  0, 32'h0,  0, 1));
    // halt, then 10 cycles of ignored requests, then reset out of HALTED
    apply(mk(1, 0, 0, 0,       0, 0, 0, 0,      0, 1, 32'h4,  0, 32'h0,  1, 0));
    for (int i = 0; i < 10; i++)
      apply(mk(1, i % 3 == 0, i % 2 == 0, 32'h900, i % 4 == 1, 32'h940, i % 3 == 1, 32'h88,
               i % 5 == 2, 0, 32'h4, 0, 32'h0, 1, 0));
    apply(mk(0, 0, 0, 0,       0, 0, 0, 0,      0, 0, 32'h0,  0, 32'h0,  0, 0));
    apply(mk(1, 0, 0, 0,       0, 0, 0, 0,      0, 0, 32'h0,  0, 32'h0,  0, 1));
    apply(mk(1, 0, 0, 0,       0, 0, 0, 0,      0, 0, 32'h4,  0, 32'h0,  0, 1));
    // exception outranks a same-cycle halt
    apply(mk(1, 0, 0, 0,       0, 0, 1, 32'h20, 0, 1, 32'h80, 1, 32'h20, 0, 1));
    apply(mk(1, 0, 0, 0,       0, 0, 0, 0,      0, 0, 32'h84, 0, 32'h20, 0, 1));
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Controller that owns and sequences the MIPS program counter. Each cycle it picks the next fetch address from sequential, branch, jump, exception or exception-return sources, holds the PC under hazard stalls, and defers redirects that arrive during a stall. It also tracks the halted state. It sits between the hazard/branch/exception logic and the instruction-fetch stage, and emits the flush pulse that IF/ID uses.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, exception handler entry address.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- stall  in  1  hazard unit hold request; 1 = freeze PC.
- branch_taken  in  1  resolved taken branch.
- branch_target  in  32  branch destination.
- jump  in  1  jump decoded.
- jump_target  in  32  jump destination.
- exc_req  in  1  exception request.
- exc_pc  in  32  PC of the faulting instruction.
- eret  in  1  return from exception.
- halt  in  1  HALT instruction retired.
- pc  out  32  current fetch address (registered).
- pc_valid  out  1  fetch address valid this cycle.
- flush  out  1  one-cycle pulse on any applied redirect.
- epc  out  32  saved exception PC.
- halted  out  1  block is in HALTED.

## Operation
- FSM states:
  - RUN: normal sequencing.
  - PEND: a redirect was latched during a stall.
  - HALTED: PC frozen.
- Redirect priority: exc_req > eret > branch_taken > jump > sequential (pc+4).
- exc_req:
  - Ignores stall and overrides any pending redirect.
  - pc <= EXC_VECTOR, epc <= exc_pc, flush=1, state <= RUN.
- eret:
  - Ignores stall.
  - pc <= epc, flush=1, state <= RUN; clears any pending redirect.
- branch_taken/jump with stall=0: pc <= target, flush=1.
- branch_taken/jump with stall=1:
  - Target latched into a pending register; state <= PEND; pc held.
  - A later branch/jump while still stalled overwrites the pending target.
- PEND with stall=0: pc <= pending target, flush=1, state <= RUN.
- RUN, no redirect, stall=0: pc <= pc+4. stall=1: pc held.
- halt:
  - Lowest priority below exc_req/eret in the same cycle.
  - state <= HALTED; pc held at its current value.
- HALTED: all inputs ignored except reset; pc_valid=0.
- Arithmetic:
  - pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - All targets have bits [1:0] forced to 0 before loading.

## Timing
- Reset values: pc=RESET_VECTOR, pc_valid=0, flush=0, epc=0, halted=0, state=RUN, pending target=0.
- pc_valid rises the first cycle after reset deasserts and stays 1 in RUN/PEND.
- Redirect latency: a request sampled at edge N makes pc equal the target after edge N, and flush is high for exactly that cycle.
- Stalled redirect: flush pulses in the cycle after the first edge with stall=0.
- Reset mid-stall or mid-PEND discards the pending target.
- Reset in HALTED returns to RUN at RESET_VECTOR.

## Configuration
- PC_STEP_EN defined:
  - Adds inputs step_mode (1) and step (1).
  - With step_mode=1, a sequential or pending advance happens only on edges where step=1; otherwise pc is held as if stall=1.
  - exc_req and eret still act immediately.
- PC_STEP_EN undefined: the ports do not exist; behaviour is identical to step_mode=0.

## Structure
- Shared package mips_pc_pkg:
  - state enum (RUN, PEND, HALTED).
  - redirect-source encoding.
  - default RESET_VECTOR/EXC_VECTOR constants.
- One combinational sub-module, pc_target_sel: priority selection plus alignment. It outputs the selected target and a redirect-source code.
- FSM, pc, epc and pending registers live in pc_sequencer.

## Test plan
- Reset held low 3 cycles, then released, no requests → pc=0, pc_valid=0 during reset; pc=0,4,8 on the following edges.
- branch_taken=1, branch_target=32'h0000_0103, stall=0 → next pc=32'h100, flush=1 for one cycle, then 32'h104.
- stall=1 with jump=1, jump_target=32'h200 for 2 cycles, then stall=0 → pc held, halted=0; pc=32'h200 after the release edge with a single flush pulse.
- exc_req=1, exc_pc=32'h44, plus branch_taken in the same cycle → pc=32'h80, epc=32'h44; then eret=1 → pc=32'h44.
- pc=32'hFFFF_FFFC, no requests → next pc=0.
- halt=1 → halted=1, pc frozen for 10 cycles despite branch/exc_req; reset low → pc=RESET_VECTOR, halted=0.
